fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Front-end controller for the 9-bit instruction ROM. Owns the 16-bit program counter and drives it into the
//  ROM's pc input. Captures the ROM's combinational instruction into a registered IF/ID slot with a valid/ready
//  handshake to decode. Applies branch/jump redirects and stops fetching when a halt opcode is fetched.
// PARAMETERS
//  RESET_PC    16'd1     PC value loaded on reset and on resume (program image starts at address 1)
//  HALT_OP     5'b11010  opcode (instr[8:4]) that ends fetching
//  PC_W        16        program counter width
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  rom_pc         out  PC_W   address to instruction ROM (equals internal pc register)
//  rom_instr      in   9      ROM data, combinational from rom_pc, valid same cycle
//  if_valid       out  1      IF/ID slot holds an instruction for decode
//  if_ready       in   1      decode accepts slot this cycle (transfer = if_valid & if_ready)
//  if_instr       out  9      captured instruction
//  if_pc          out  PC_W   address the instruction was fetched from
//  redirect_valid in   1      branch/jump resolved taken this cycle
//  redirect_pc    in   PC_W   target of redirect
//  stall          in   1      hazard unit freeze: hold pc and slot
//  resume         in   1      one-cycle pulse: leave HALTED, restart at RESET_PC
//  halted         out  1      fetch stopped on halt opcode
//  fetch_count    out  16     instructions transferred to decode, saturating
// BEHAVIOUR
//  Reset (sync): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, state=RUN, halted=0, fetch_count=0.
//  FSM states: RUN, HALTED.
//  slot_free = ~if_valid | if_ready. fetch = (state==RUN) & slot_free & ~stall & ~redirect_valid.
//  Priority each cycle in RUN: redirect_valid > stall > fetch.
//  redirect_valid (RUN): pc<=redirect_pc; if_valid<=0 (flush, even if if_ready); no capture; stall ignored.
//   fetch_count still increments if if_valid & if_ready that cycle (decode took it before the flush).
//  stall (no redirect): pc, if_instr, if_pc unchanged; if_valid<=if_valid & ~if_ready.
//  fetch: if_instr<=rom_instr, if_pc<=pc, if_valid<=1, pc<=pc+1 (wraps 16'hFFFF->16'h0000).
//  No fetch and slot consumed (if_valid & if_ready): if_valid<=0.
//  Latency: instruction at address A is in the slot the cycle after pc==A with fetch asserted; one fetch/cycle max,
//   back-to-back transfers with if_ready held high.
//  Halt: when fetch captures rom_instr[8:4]==HALT_OP, state<=HALTED, halted<=1, pc<=pc (NOT incremented).
//   The halt instruction is still delivered to decode via the slot; slot drains normally.
//  HALTED: no fetches; redirect_valid and stall ignored; if_valid clears once consumed.
//   resume: state<=RUN, halted<=0, pc<=RESET_PC, if_valid<=0 (stale slot dropped). resume in RUN ignored.
//  Halt captured in same cycle as redirect: impossible by priority (redirect blocks capture).
//  fetch_count: +1 per transfer, saturates at 16'hFFFF; cleared only by reset.
//  reset mid-operation overrides everything, including an in-flight halt or redirect.
//  rom_pc is a direct copy of the pc register (no combinational path from inputs).
// TESTING
//  1 Reset, if_ready=1, ROM program 1..3 then halt at 4: slot shows pc 1,2,3,4 on consecutive cycles; halted=1
//    the cycle after pc 4 captured; rom_pc stays 4; fetch_count=4 after slot drains.
//  2 if_ready=0 for 3 cycles after first capture at pc 1: if_instr/if_pc held at pc 1, rom_pc held at 2;
//    release -> pc 2 delivered next cycle, no duplicate or skipped address.
//  3 redirect_valid with redirect_pc=14 while slot holds pc 5 and if_ready=0: slot flushed (if_valid=0 next cycle),
//    next captured if_pc=14; fetch_count unchanged.
//  4 stall=1 and redirect_valid=1 same cycle, target 26: redirect wins, rom_pc=26 next cycle.
//  5 After halt, pulse resume: halted=0, rom_pc=1, if_valid=0 that cycle, pc 1 captured the following cycle.
//  6 Force pc to 16'hFFFF via redirect: captures if_pc=FFFF then rom_pc=0000; assert reset mid-stall -> all outputs
//    at reset values next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the program counter, captures the ROM
// word into a registered IF/ID slot with a valid/ready handshake, applies
// branch/jump redirects and stops fetching once a halt opcode is captured.
module fetch_sequencer #(
    parameter int               PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = 16'd1,
    parameter logic [4:0]       HALT_OP  = 5'b11010
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] rom_pc,
    input  logic [8:0]      rom_instr,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [8:0]      if_instr,
    output logic [PC_W-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    input  logic            resume,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [PC_W-1:0] pc;

    logic transfer;
    logic slot_free;
    logic is_halt_op;

    // Handshake and decode of the word currently presented by the ROM.
    always_comb begin
        transfer   = if_valid & if_ready;
        slot_free  = ~if_valid | if_ready;
        is_halt_op = (rom_instr[8:4] == HALT_OP);
    end

    // The ROM address is the pc register itself, never a combinational mux.
    assign rom_pc = pc;

    // Fetch FSM: pc, IF/ID slot, halt state and transfer counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 9'd0;
            if_pc       <= '0;
            halted      <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            // Decode may take the slot in the same cycle it gets flushed, so
            // counting is independent of the state branches below.
            if (transfer && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end

            case (state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        if_valid <= if_valid & ~if_ready;
                    end else if (slot_free) begin
                        if_instr <= rom_instr;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        if (is_halt_op) begin
                            // pc parks on the halt address; resume restarts at RESET_PC
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state    <= ST_RUN;
                        halted   <= 1'b0;
                        pc       <= RESET_PC;
                        if_valid <= 1'b0;
                    end else if (transfer) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
